// File: rtl/widen_pkt_fifo.sv
// Packet FIFO packing NARROW_W write beats into RATIO-lane wide read words with commit/abort.
// Define WIDEN_DROP_ON_FULL_EN to drop overflowing packets instead of backpressuring the writer.
module widen_pkt_fifo #(
    parameter int NARROW_W = 16,
    parameter int RATIO    = 4,
    parameter int DEPTH    = 512,
    parameter int DROP_W   = 16,
    localparam int WIDE_W  = NARROW_W * RATIO,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [NARROW_W-1:0] wr_data_i,
    input  logic                wr_last_i,
    input  logic                wr_abort_i,
    output logic                rd_valid_o,
    input  logic                rd_ready_i,
    output logic [WIDE_W-1:0]   rd_data_o,
    output logic [RATIO-1:0]    rd_keep_o,
    output logic                rd_last_o,
    output logic [AW:0]         pkt_cnt_o,
    output logic [AW:0]         words_o,
    output logic [DROP_W-1:0]   drop_cnt_o
);

    localparam int LW = $clog2(RATIO);
    localparam int MW = WIDE_W + RATIO + 1;

    typedef enum logic [1:0] {
        RD_EMPTY,
        RD_FETCH,
        RD_HOLD
    } rd_state_t;

    logic [MW-1:0]     mem [DEPTH];
    logic [AW:0]       wr_ptr, commit_ptr, rd_ptr;
    logic [AW:0]       used;
    logic              full;
    logic [LW-1:0]     lane;
    logic [WIDE_W-1:0] asm_data, word_data;
    logic [RATIO-1:0]  asm_keep, word_keep;
    logic              accept, do_abort, do_write, do_commit, do_drop;
    logic              rd_pending, rd_last_hs;
    rd_state_t         rd_state;

    assign used       = wr_ptr - rd_ptr;
    assign full       = (used == (AW+1)'(DEPTH));
    assign words_o    = commit_ptr - rd_ptr;
    assign rd_pending = (rd_ptr != commit_ptr);
    assign rd_last_hs = rd_valid_o & rd_ready_i & rd_last_o;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        word_data = asm_data;
        word_keep = asm_keep;
        word_data[lane*NARROW_W +: NARROW_W] = wr_data_i;
        word_keep[lane] = 1'b1;
    end

`ifdef WIDEN_DROP_ON_FULL_EN
    logic discard, overflow;

    assign wr_ready_o = 1'b1;
    assign accept     = wr_valid_i & ~discard & ~full;
    assign do_abort   = wr_valid_i & wr_abort_i & ~discard;
    assign overflow   = wr_valid_i & ~wr_abort_i & ~discard & full;
    assign do_drop    = do_abort | overflow;
`else
    assign wr_ready_o = ~full;
    assign accept     = wr_valid_i & ~full;
    // Abort ignores full so an oversize packet stuck against a full FIFO can still be dropped.
    assign do_abort   = wr_valid_i & wr_abort_i;
    assign do_drop    = do_abort;
`endif

    assign do_commit = accept & ~wr_abort_i & wr_last_i;
    assign do_write  = accept & ~wr_abort_i & (wr_last_i | (lane == LW'(RATIO-1)));

    // NOTE: storage has no reset; stale words are unreachable because the pointers do reset.
    always_ff @(posedge clk_i) begin
        if (do_write)
            mem[wr_ptr[AW-1:0]] <= {wr_last_i, word_keep, word_data};
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            lane       <= '0;
            asm_data   <= '0;
            asm_keep   <= '0;
`ifdef WIDEN_DROP_ON_FULL_EN
            discard    <= 1'b0;
`endif
        end else if (do_abort) begin
            wr_ptr   <= commit_ptr;
            lane     <= '0;
            asm_data <= '0;
            asm_keep <= '0;
        end
`ifdef WIDEN_DROP_ON_FULL_EN
        else if (overflow) begin
            wr_ptr   <= commit_ptr;
            lane     <= '0;
            asm_data <= '0;
            asm_keep <= '0;
            discard  <= ~wr_last_i;
        end else if (discard) begin
            if (wr_valid_i & (wr_last_i | wr_abort_i))
                discard <= 1'b0;
        end
`endif
        else if (accept) begin
            if (do_write) begin
                wr_ptr   <= wr_ptr + 1'b1;
                lane     <= '0;
                asm_data <= '0;
                asm_keep <= '0;
                if (do_commit)
                    commit_ptr <= wr_ptr + 1'b1;
            end else begin
                lane     <= lane + 1'b1;
                asm_data <= word_data;
                asm_keep <= word_keep;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            drop_cnt_o <= '0;
        else if (do_drop && drop_cnt_o != '1)
            drop_cnt_o <= drop_cnt_o + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            pkt_cnt_o <= '0;
        else if (do_commit && !rd_last_hs)
            pkt_cnt_o <= pkt_cnt_o + 1'b1;
        else if (!do_commit && rd_last_hs)
            pkt_cnt_o <= pkt_cnt_o - 1'b1;
    end

    // The output register is the synchronous read port; HOLD refetches in place for 1 word/cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state   <= RD_EMPTY;
            rd_ptr     <= '0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_keep_o  <= '0;
            rd_last_o  <= 1'b0;
        end else begin
            case (rd_state)
                RD_EMPTY: begin
                    if (rd_pending)
                        rd_state <= RD_FETCH;
                end
                RD_FETCH: begin
                    {rd_last_o, rd_keep_o, rd_data_o} <= mem[rd_ptr[AW-1:0]];
                    rd_ptr     <= rd_ptr + 1'b1;
                    rd_valid_o <= 1'b1;
                    rd_state   <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (rd_ready_i) begin
                        if (rd_pending) begin
                            {rd_last_o, rd_keep_o, rd_data_o} <= mem[rd_ptr[AW-1:0]];
                            rd_ptr <= rd_ptr + 1'b1;
                        end else begin
                            rd_valid_o <= 1'b0;
                            rd_state   <= RD_EMPTY;
                        end
                    end
                end
                default: rd_state <= RD_EMPTY;
            endcase
        end
    end

endmodule
